// File: rtl/rbm_infer_engine.sv
// Inference sequencer for a two-layer binary RBM classifier.
// Walks image/weight/bias ROMs (1-cycle read latency, addresses issued one
// cycle ahead), computes hidden then class units, and accumulates class
// spikes over several iterations. It then reports the argmax class.
module rbm_infer_engine #(
    parameter int          N_IN      = 784,
    parameter int          N_HID     = 441,
    parameter int          N_OUT     = 10,
    parameter int          W_WIDTH   = 12,
    parameter int          ACC_WIDTH = 24,
    parameter int          CNT_WIDTH = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [CNT_WIDTH-1:0]     iterations,
    input  logic                     noise_en,
    output logic [$clog2(N_IN)-1:0]  img_addr,
    input  logic                     img_bit,
    output logic [$clog2(N_IN)-1:0]  hw_row,
    output logic [$clog2(N_HID)-1:0] hw_col,
    input  logic [W_WIDTH-1:0]       hw_data,
    output logic [$clog2(N_HID)-1:0] hb_addr,
    input  logic [W_WIDTH-1:0]       hb_data,
    input  logic                     hsw_data,
    output logic [$clog2(N_HID)-1:0] cw_row,
    output logic [$clog2(N_OUT)-1:0] cw_col,
    input  logic [W_WIDTH-1:0]       cw_data,
    output logic [$clog2(N_OUT)-1:0] cb_addr,
    input  logic [W_WIDTH-1:0]       cb_data,
    input  logic [$clog2(N_OUT)-1:0] cnt_sel,
    output logic [CNT_WIDTH-1:0]     cnt_data,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(N_OUT)-1:0] class_out
);
    localparam int IA = $clog2(N_IN);
    localparam int HA = $clog2(N_HID);
    localparam int OA = $clog2(N_OUT);
    localparam logic [IA-1:0] IN_LAST  = IA'(N_IN - 1);
    localparam logic [HA-1:0] HID_LAST = HA'(N_HID - 1);
    localparam logic [OA-1:0] OUT_LAST = OA'(N_OUT - 1);

    typedef enum logic [3:0] {
        IDLE, H_ACC, H_BIAS, H_DEC, C_ACC, C_BIAS, C_DEC, ARGMAX, DONE
    } state_t;

    state_t state, state_nx;

    logic [IA-1:0]               in_idx;    // pixel being accumulated
    logic [HA-1:0]               hu_idx;    // hidden unit being computed
    logic [HA-1:0]               hc_idx;    // hidden bit feeding a class unit
    logic [OA-1:0]               cu_idx;    // class unit / argmax scan index
    logic [CNT_WIDTH-1:0]        it_left;
    logic                        noise_on;
    logic                        sw;
    logic signed [ACC_WIDTH-1:0] acc;
    logic [N_HID-1:0]            hid_bits;
    logic [CNT_WIDTH-1:0]        cnt [N_OUT];
    logic [CNT_WIDTH-1:0]        best_val;
    logic [OA-1:0]               best_idx;
    logic [15:0]                 lfsr;

    logic accept, in_last, hu_last, hc_last, cu_last, it_last, fire;
    logic signed [ACC_WIDTH-1:0] hw_ext, hb_ext, cw_ext, cb_ext, noise, sum;

    // A start landing on the done-pulse cycle is dropped, even though state is IDLE.
    assign accept  = (state == IDLE) && start && !done;
    assign in_last = (in_idx == IN_LAST);
    assign hu_last = (hu_idx == HID_LAST);
    assign hc_last = (hc_idx == HID_LAST);
    assign cu_last = (cu_idx == OUT_LAST);
    assign it_last = (it_left == CNT_WIDTH'(1));

    assign hw_ext = ACC_WIDTH'($signed(hw_data));
    assign hb_ext = ACC_WIDTH'($signed(hb_data));
    assign cw_ext = ACC_WIDTH'($signed(cw_data));
    assign cb_ext = ACC_WIDTH'($signed(cb_data));
    assign noise  = noise_on ? ACC_WIDTH'($signed(lfsr[W_WIDTH-1:0])) : '0;
    assign sum    = acc + noise;
    // Strictly positive: a sum of exactly zero does not fire.
    assign fire   = !sum[ACC_WIDTH-1] && (sum != '0);

    assign cnt_data = cnt[cnt_sel];
    assign hb_addr  = hu_idx;
    assign cb_addr  = cu_idx;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic.
    // NOTE: each output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (accept) state_nx = H_ACC;
            H_ACC:  if (in_last) state_nx = H_BIAS;
            H_BIAS: state_nx = H_DEC;
            H_DEC:  state_nx = hu_last ? C_ACC : H_ACC;
            C_ACC:  if (hc_last) state_nx = C_BIAS;
            C_BIAS: state_nx = C_DEC;
            C_DEC: begin
                if (!cu_last)     state_nx = C_ACC;
                else if (it_last) state_nx = ARGMAX;
                else              state_nx = H_ACC;
            end
            ARGMAX: if (cu_last) state_nx = DONE;
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Prefetch addresses: each one names the word consumed in the next cycle.
    always_comb begin
        img_addr = '0;
        hw_row   = '0;
        hw_col   = '0;
        cw_row   = '0;
        cw_col   = '0;
        case (state)
            H_ACC: begin
                if (!in_last) begin
                    img_addr = in_idx + 1'b1;
                    hw_row   = in_idx + 1'b1;
                end
                hw_col = hu_idx;
            end
            H_DEC: hw_col = hu_last ? '0 : hu_idx + 1'b1;
            C_ACC: begin
                if (!hc_last) cw_row = hc_idx + 1'b1;
                cw_col = cu_idx;
            end
            C_DEC: cw_col = cu_last ? '0 : cu_idx + 1'b1;
            default: ;
        endcase
    end

    // Datapath: accumulate, decide, count spikes, scan for the winner.
    always_ff @(posedge clock) begin
        if (reset) begin
            in_idx    <= '0;
            hu_idx    <= '0;
            hc_idx    <= '0;
            cu_idx    <= '0;
            it_left   <= '0;
            noise_on  <= 1'b0;
            sw        <= 1'b0;
            acc       <= '0;
            hid_bits  <= '0;
            best_val  <= '0;
            best_idx  <= '0;
            lfsr      <= LFSR_SEED;
            busy      <= 1'b0;
            done      <= 1'b0;
            class_out <= '0;
            // NOTE: the counter file is a few flops, not a RAM, so it is reset like other state.
            for (int k = 0; k < N_OUT; k++) cnt[k] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    acc <= '0;
                    if (accept) begin
                        busy     <= 1'b1;
                        noise_on <= noise_en;
                        it_left  <= (iterations == '0) ? CNT_WIDTH'(1) : iterations;
                        for (int k = 0; k < N_OUT; k++) cnt[k] <= '0;
                    end
                end
                H_ACC: begin
                    if (img_bit) acc <= acc + hw_ext;
                    in_idx <= in_last ? '0 : in_idx + 1'b1;
                end
                H_BIAS: begin
                    acc <= acc + hb_ext;
                    sw  <= hsw_data;
                end
                H_DEC: begin
                    hid_bits[hu_idx] <= sw && fire;
                    acc    <= '0;
                    hu_idx <= hu_last ? '0 : hu_idx + 1'b1;
                    if (noise_on) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                end
                C_ACC: begin
                    if (hid_bits[hc_idx]) acc <= acc + cw_ext;
                    hc_idx <= hc_last ? '0 : hc_idx + 1'b1;
                end
                C_BIAS: acc <= acc + cb_ext;
                C_DEC: begin
                    if (fire && (cnt[cu_idx] != '1)) cnt[cu_idx] <= cnt[cu_idx] + 1'b1;
                    acc    <= '0;
                    cu_idx <= cu_last ? '0 : cu_idx + 1'b1;
                    if (cu_last) it_left <= it_left - 1'b1;
                    if (noise_on) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                end
                ARGMAX: begin
                    // Strict compare keeps the lowest index on ties.
                    if ((cu_idx == '0) || (cnt[cu_idx] > best_val)) begin
                        best_val <= cnt[cu_idx];
                        best_idx <= cu_idx;
                    end
                    cu_idx <= cu_last ? '0 : cu_idx + 1'b1;
                end
                DONE: begin
                    class_out <= best_idx;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rbm_infer_engine.sv
// Self-checking bench for rbm_infer_engine on a small build (4 pixels,
// 3 hidden, 2 classes). A reference model predicts counters, class and
// latency; predictions are queued at start and compared at done.
module tb_rbm_infer_engine;
    localparam int N_IN  = 4;
    localparam int N_HID = 3;
    localparam int N_OUT = 2;
    localparam int W     = 12;
    localparam int P     = N_HID * (N_IN + 2) + N_OUT * (N_HID + 2);
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        string tag;
        int    c0;
        int    c1;
        int    cls;
        int    lat;
    } exp_t;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [15:0] m_lfsr = SEED;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start_a = 1'b0, start_s = 1'b0;
    logic [7:0] iterations = '0;
    logic       noise_en = 1'b0;
    logic       cnt_sel = 1'b0;

    bit img_mem [N_IN];
    int hw_mem  [N_IN][N_HID];
    int hb_mem  [N_HID];
    bit hsw_mem [N_HID];
    int cw_mem  [N_HID][N_OUT];
    int cb_mem  [N_OUT];

    logic [1:0]   img_addr_a, hw_row_a, hw_col_a, hb_addr_a, cw_row_a;
    logic         cw_col_a, cb_addr_a, class_a, busy_a, done_a;
    logic         img_bit_a, hsw_a;
    logic [W-1:0] hw_data_a, hb_data_a, cw_data_a, cb_data_a;
    logic [7:0]   cnt_data_a;

    logic [1:0]   img_addr_s, hw_row_s, hw_col_s, hb_addr_s, cw_row_s;
    logic         cw_col_s, cb_addr_s, class_s, busy_s, done_s;
    logic         img_bit_s, hsw_s;
    logic [W-1:0] hw_data_s, hb_data_s, cw_data_s, cb_data_s;
    logic [1:0]   cnt_data_s;

    always #5 clock = ~clock;

    rbm_infer_engine #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .W_WIDTH(W),
                       .ACC_WIDTH(24), .CNT_WIDTH(8), .LFSR_SEED(SEED)) dut (
        .clock(clock), .reset(reset), .start(start_a), .iterations(iterations),
        .noise_en(noise_en), .img_addr(img_addr_a), .img_bit(img_bit_a),
        .hw_row(hw_row_a), .hw_col(hw_col_a), .hw_data(hw_data_a),
        .hb_addr(hb_addr_a), .hb_data(hb_data_a), .hsw_data(hsw_a),
        .cw_row(cw_row_a), .cw_col(cw_col_a), .cw_data(cw_data_a),
        .cb_addr(cb_addr_a), .cb_data(cb_data_a), .cnt_sel(cnt_sel),
        .cnt_data(cnt_data_a), .busy(busy_a), .done(done_a), .class_out(class_a)
    );

    rbm_infer_engine #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .W_WIDTH(W),
                       .ACC_WIDTH(24), .CNT_WIDTH(2), .LFSR_SEED(SEED)) dut_sat (
        .clock(clock), .reset(reset), .start(start_s), .iterations(iterations[1:0]),
        .noise_en(noise_en), .img_addr(img_addr_s), .img_bit(img_bit_s),
        .hw_row(hw_row_s), .hw_col(hw_col_s), .hw_data(hw_data_s),
        .hb_addr(hb_addr_s), .hb_data(hb_data_s), .hsw_data(hsw_s),
        .cw_row(cw_row_s), .cw_col(cw_col_s), .cw_data(cw_data_s),
        .cb_addr(cb_addr_s), .cb_data(cb_data_s), .cnt_sel(cnt_sel),
        .cnt_data(cnt_data_s), .busy(busy_s), .done(done_s), .class_out(class_s)
    );

    // Synchronous ROM models, one read port set per engine.
    always @(posedge clock) begin
        img_bit_a <= img_mem[img_addr_a];
        hw_data_a <= W'(hw_mem[hw_row_a][hw_col_a]);
        hb_data_a <= W'(hb_mem[hb_addr_a]);
        hsw_a     <= hsw_mem[hb_addr_a];
        cw_data_a <= W'(cw_mem[cw_row_a][cw_col_a]);
        cb_data_a <= W'(cb_mem[cb_addr_a]);
    end

    always @(posedge clock) begin
        img_bit_s <= img_mem[img_addr_s];
        hw_data_s <= W'(hw_mem[hw_row_s][hw_col_s]);
        hb_data_s <= W'(hb_mem[hb_addr_s]);
        hsw_s     <= hsw_mem[hb_addr_s];
        cw_data_s <= W'(cw_mem[cw_row_s][cw_col_s]);
        cb_data_s <= W'(cb_mem[cb_addr_s]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic int noise_of(input logic [15:0] v);
        logic signed [11:0] s;
        s = v[11:0];
        return int'(s);
    endfunction

    // Reference model of one inference; advances the model LFSR like the engine.
    task automatic model(input int iters, input bit nz, input int cmax,
                         output int c0, output int c1, output int cls);
        int cnt [N_OUT];
        bit hbit [N_HID];
        int acc, nv, it;
        it = (iters == 0) ? 1 : iters;
        foreach (cnt[k]) cnt[k] = 0;
        for (int r = 0; r < it; r++) begin
            for (int j = 0; j < N_HID; j++) begin
                acc = hb_mem[j];
                for (int i = 0; i < N_IN; i++) if (img_mem[i]) acc += hw_mem[i][j];
                nv = nz ? noise_of(m_lfsr) : 0;
                hbit[j] = hsw_mem[j] && (acc + nv > 0);
                if (nz) m_lfsr = lfsr_next(m_lfsr);
            end
            for (int k = 0; k < N_OUT; k++) begin
                acc = cb_mem[k];
                for (int h = 0; h < N_HID; h++) if (hbit[h]) acc += cw_mem[h][k];
                nv = nz ? noise_of(m_lfsr) : 0;
                if ((acc + nv > 0) && cnt[k] < cmax) cnt[k]++;
                if (nz) m_lfsr = lfsr_next(m_lfsr);
            end
        end
        c0  = cnt[0];
        c1  = cnt[1];
        cls = (cnt[1] > cnt[0]) ? 1 : 0;
    endtask

    task automatic load_det();
        for (int i = 0; i < N_IN; i++) begin
            img_mem[i] = 1'b1;
            for (int j = 0; j < N_HID; j++) hw_mem[i][j] = 1;
        end
        for (int j = 0; j < N_HID; j++) begin
            hb_mem[j]    = 0;
            hsw_mem[j]   = 1'b1;
            cw_mem[j][0] = 1;
            cw_mem[j][1] = -1;
        end
        cb_mem[0] = 0;
        cb_mem[1] = 0;
    endtask

    task automatic load_noisy();
        for (int i = 0; i < N_IN; i++) begin
            img_mem[i] = (i != 2);
            for (int j = 0; j < N_HID; j++) hw_mem[i][j] = (i * 3 + j * 5) % 7 - 3;
        end
        for (int j = 0; j < N_HID; j++) begin
            hb_mem[j]    = j - 1;
            hsw_mem[j]   = 1'b1;
            cw_mem[j][0] = 2 - j;
            cw_mem[j][1] = j - 1;
        end
        cb_mem[0] = -1;
        cb_mem[1] = 1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        m_lfsr = SEED;
    endtask

    task automatic drive_start(input bit sat, input logic v);
        if (sat) start_s = v;
        else     start_a = v;
    endtask

    // One inference: push prediction, start, wait (bounded) for done, pop and compare.
    task automatic run(input string tag, input bit sat, input int iters, input bit nz, input bit glitch);
        exp_t e, g;
        int   cyc;
        model(iters, nz, sat ? 3 : 255, e.c0, e.c1, e.cls);
        e.tag = tag;
        e.lat = ((iters == 0) ? 1 : iters) * P + N_OUT + 1;
        sb.push_back(e);
        iterations = 8'(iters);
        noise_en   = nz;
        drive_start(sat, 1'b1);
        @(negedge clock);
        drive_start(sat, 1'b0);
        cyc = 1;
        check({tag, "_busy"}, sat ? 32'(busy_s) : 32'(busy_a), 1);
        while (!(sat ? done_s : done_a) && cyc < e.lat + 20) begin
            drive_start(sat, glitch && (cyc == 10));
            @(negedge clock);
            cyc++;
        end
        drive_start(sat, 1'b0);
        g = sb.pop_front();
        if (!(sat ? done_s : done_a)) begin
            check({g.tag, "_timeout"}, 0, 1);
            return;
        end
        check({g.tag, "_latency"}, cyc - 1, g.lat);
        cnt_sel = 1'b0;
        #1 check({g.tag, "_cnt0"}, sat ? 32'(cnt_data_s) : 32'(cnt_data_a), g.c0);
        cnt_sel = 1'b1;
        #1 check({g.tag, "_cnt1"}, sat ? 32'(cnt_data_s) : 32'(cnt_data_a), g.c1);
        check({g.tag, "_class"}, sat ? 32'(class_s) : 32'(class_a), g.cls);
        // A start during the done cycle must be ignored.
        drive_start(sat, 1'b1);
        @(negedge clock);
        drive_start(sat, 1'b0);
        check({g.tag, "_done_pulse"}, sat ? 32'(done_s) : 32'(done_a), 0);
        check({g.tag, "_start_in_done"}, sat ? 32'(busy_s) : 32'(busy_a), 0);
    endtask

    initial begin
        bit seen;
        load_det();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        m_lfsr = SEED;

        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_class", class_a, 0);
        check("rst_addr", {img_addr_a, hw_row_a, hw_col_a, hb_addr_a, cw_row_a, cw_col_a, cb_addr_a}, 0);
        check("rst_cnt", cnt_data_a, 0);
        check("rst_sat_busy", busy_s, 0);

        run("det", 1'b0, 3, 1'b0, 1'b0);
        run("glitch", 1'b0, 2, 1'b0, 1'b1);
        run("sat", 1'b1, 3, 1'b0, 1'b0);

        foreach (img_mem[i]) img_mem[i] = 1'b0;
        run("zero_sum", 1'b0, 2, 1'b0, 1'b0);

        load_det();
        foreach (hsw_mem[j]) hsw_mem[j] = 1'b0;
        cb_mem[0] = -1;
        cb_mem[1] = 2;
        run("switch_bias", 1'b0, 4, 1'b0, 1'b0);

        // Abort a run with reset at cycle 20.
        load_det();
        iterations = 8'd3;
        noise_en   = 1'b0;
        start_a    = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        repeat (19) @(negedge clock);
        do_reset();
        check("abort_busy", busy_a, 0);
        check("abort_class", class_a, 0);
        cnt_sel = 1'b0;
        #1 check("abort_cnt0", cnt_data_a, 0);
        cnt_sel = 1'b1;
        #1 check("abort_cnt1", cnt_data_a, 0);
        seen = 1'b0;
        repeat (100) begin
            @(negedge clock);
            if (done_a) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);

        run("after_abort", 1'b0, 1, 1'b0, 1'b0);

        load_noisy();
        do_reset();
        run("noise_a", 1'b0, 3, 1'b1, 1'b0);
        do_reset();
        run("noise_b", 1'b0, 3, 1'b1, 1'b0);

        load_det();
        run("iter_zero", 1'b0, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
